crossbar_slave_responder: RTL and testbench
===========================================

// Module: crossbar_slave_responder
// PURPOSE
//  Slave-side responder for the crossbar2x2 req/ack bus. Sits on a crossbar slave port and accepts
//  read/write requests. Each request is answered with exactly one single-cycle ack after a
//  programmable latency. Backing store is an internal word-addressed memory.
//  Counts completed transactions for bench and bring-up visibility.
// PARAMETERS
//  ADDR_W     31   slave-port address width (crossbar strips the slave-select MSB)
//  DATA_W     32   data width
//  MEM_DEPTH  256  words of backing store, power of two; IDX_W = $clog2(MEM_DEPTH)
//  LATENCY    1    cycles from request capture to ack, legal range 1..15
//  CNT_W      16   width of transaction counters
// PORTS
//  clock        in   1       single clock, rising edge
//  reset        in   1       synchronous, active-high
//  slave_req    in   1       request valid; master holds it and all fields until it samples ack
//  slave_cmd    in   1       1 = write, 0 = read
//  slave_addr   in   ADDR_W  word address
//  slave_wdata  in   DATA_W  write data
//  slave_ack    out  1       one-cycle completion pulse
//  slave_rdata  out  DATA_W  read data; valid only when slave_ack=1 and the cmd was a read
//  wr_count     out  CNT_W   completed writes
//  rd_count     out  CNT_W   completed reads
// BEHAVIOUR
//  - Reset (sampled at posedge): state<=IDLE; slave_ack=0; slave_rdata=0; both counters=0;
//    latched request is discarded. Memory contents are NOT cleared.
//  - FSM states: IDLE, WAIT, ACK.
//    IDLE: if slave_req=1, capture cmd, addr and wdata and load lat_cnt<=LATENCY-1.
//          Go to ACK if LATENCY=1, otherwise go to WAIT.
//    WAIT: decrement lat_cnt. Go to ACK when lat_cnt==1 at the clock edge.
//          slave_req is ignored in WAIT; the captured values are used.
//    ACK:  slave_ack=1 for exactly this cycle, then always return to IDLE.
//          No request is accepted in the ACK cycle.
//  - Latency: req first high in cycle N -> captured at end of N -> ack high in cycle N+LATENCY.
//  - Write: mem[addr[IDX_W-1:0]] <= wdata at the edge ending the ACK cycle. wr_count +1 at that edge.
//  - Read: slave_rdata = mem[addr[IDX_W-1:0]] during the ACK cycle.
//    slave_rdata is 0 in every other cycle. rd_count +1 at the edge ending the ACK cycle.
//  - Address bits above IDX_W are ignored, so the memory aliases; no error is signalled.
//  - Back-to-back: master drops req in the cycle after ack. If req is still high in IDLE, that is
//    a new transaction and must be served, so the minimum spacing is LATENCY+1 cycles.
//  - A read issued after a write to the same index returns the new data.
//  - Counters wrap modulo 2^CNT_W with no saturation.
//  - Reset during WAIT or ACK: no ack is produced, no memory write happens, no counter increments.
//  - slave_cmd, slave_addr and slave_wdata are don't-care while slave_req=0.
// STRUCTURE
//  - Package xbar_pkg: CMD_READ=1'b0, CMD_WRITE=1'b1, XBAR_ADDR_W=31, XBAR_DATA_W=32, FSM state enum.
//  - Sub-module xbar_slave_mem: single-port synchronous-write memory with combinational read,
//    parameters DEPTH and DATA_W, ports clock, we, idx, wdata, rdata.
//  - Top-level holds the FSM, latency counter, request capture registers and counters.
// TESTING
//  1. LATENCY=1: write addr 0xA, data 0xA -> ack in cycle N+1 for 1 cycle; wr_count=1.
//     Then read addr 0xA -> slave_rdata=0x0000000A with ack; rd_count=1.
//  2. LATENCY=3: read request held high -> ack exactly 3 cycles after capture, single pulse.
//     Changing addr during WAIT does not change the returned data.
//  3. Aliasing with MEM_DEPTH=256: write 0x55 to addr 0x10B, then read addr 0x00B -> rdata=0x55.
//  4. req held high across ack -> second ack arrives LATENCY+1 cycles after the first; wr_count=2.
//  5. Assert reset during WAIT of a write to addr 0x3 -> no ack, wr_count=0.
//     A later read of 0x3 returns the old contents.
//  6. Idle with req=0 for 10 cycles -> slave_ack=0 and slave_rdata=0 throughout.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared definitions for the crossbar2x2 slave-side blocks: command encoding,
// default bus widths and the responder FSM state type.
package xbar_pkg;

    // Command encoding carried on slave_cmd
    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // Default slave-port widths (crossbar strips the slave-select MSB of the address)
    localparam int XBAR_ADDR_W = 31;
    localparam int XBAR_DATA_W = 32;

    // Width of the programmable-latency down-counter (latency range 1..15)
    localparam int XBAR_LAT_W  = 4;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } xbar_state_e;

endpackage : xbar_pkg

// File: rtl/xbar_slave_mem.sv
// Single-port backing store for the slave responder: synchronous write,
// combinational read on the same index. Contents are never reset.
module xbar_slave_mem #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port: store wdata at idx on the rising edge when enabled
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[idx] <= wdata;
        end
    end

    // Read port is combinational so the responder can register the word on the ACK transition
    assign rdata = mem_r[idx];

endmodule : xbar_slave_mem

// File: rtl/crossbar_slave_responder.sv
// Slave-side responder for the crossbar2x2 req/ack bus. Captures one request,
// waits a programmable number of cycles, then returns a single-cycle ack with
// read data from (or write data into) an internal word-addressed memory.
// Completed reads and writes are counted.
module crossbar_slave_responder
    import xbar_pkg::*;
#(
    parameter int ADDR_W    = XBAR_ADDR_W,
    parameter int DATA_W    = XBAR_DATA_W,
    parameter int MEM_DEPTH = 256,
    parameter int LATENCY   = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              slave_req,
    input  logic              slave_cmd,
    input  logic [ADDR_W-1:0] slave_addr,
    input  logic [DATA_W-1:0] slave_wdata,
    output logic              slave_ack,
    output logic [DATA_W-1:0] slave_rdata,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int LAT_W = XBAR_LAT_W;

    // Value loaded into the latency counter at capture time
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);
    // Single-cycle latency skips WAIT and goes straight to ACK
    localparam logic             LAT_ONE  = (LATENCY == 1) ? 1'b1 : 1'b0;

    // FSM and captured request
    xbar_state_e       state_r;
    logic              cmd_r;
    logic [IDX_W-1:0]  idx_r;
    logic [DATA_W-1:0] wdata_r;
    logic [LAT_W-1:0]  lat_cnt_r;

    // Registered outputs
    logic              ack_r;
    logic [DATA_W-1:0] rdata_r;
    logic [CNT_W-1:0]  wr_count_r;
    logic [CNT_W-1:0]  rd_count_r;

    // Memory interface and helpers
    logic [IDX_W-1:0]  mem_idx_s;
    logic              mem_we_s;
    logic [DATA_W-1:0] mem_rdata_s;
    logic              cmd_sel_s;
    logic [DATA_W-1:0] rd_val_s;
    logic              addr_hi_unused_s;

    // Address bits above the memory index are deliberately ignored (memory aliases)
    assign addr_hi_unused_s = ^slave_addr[ADDR_W-1:IDX_W];

    // Memory index: in IDLE look at the live bus so a LATENCY=1 read can load its
    // data on the capture edge; otherwise use the captured index
    always_comb begin
        mem_idx_s = idx_r;
        if (state_r == ST_IDLE) begin
            mem_idx_s = slave_addr[IDX_W-1:0];
        end else begin
            mem_idx_s = idx_r;
        end
    end

    // Command and read value presented to the ACK transition; writes return zero data
    always_comb begin
        cmd_sel_s = cmd_r;
        rd_val_s  = {DATA_W{1'b0}};
        if (state_r == ST_IDLE) begin
            cmd_sel_s = slave_cmd;
        end else begin
            cmd_sel_s = cmd_r;
        end
        if (cmd_sel_s == CMD_READ) begin
            rd_val_s = mem_rdata_s;
        end else begin
            rd_val_s = {DATA_W{1'b0}};
        end
    end

    // Write strobe on the edge ending the ACK cycle; a reset at that edge cancels it
    always_comb begin
        mem_we_s = 1'b0;
        if (!reset && (state_r == ST_ACK) && (cmd_r == CMD_WRITE)) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    xbar_slave_mem #(
        .DEPTH  (MEM_DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clock (clock),
        .we    (mem_we_s),
        .idx   (mem_idx_s),
        .wdata (wdata_r),
        .rdata (mem_rdata_s)
    );

    // Responder FSM: capture, latency countdown, single-cycle ack, counters
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cmd_r      <= CMD_READ;
            idx_r      <= {IDX_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            lat_cnt_r  <= {LAT_W{1'b0}};
            ack_r      <= 1'b0;
            rdata_r    <= {DATA_W{1'b0}};
            wr_count_r <= {CNT_W{1'b0}};
            rd_count_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack_r   <= 1'b0;
                    rdata_r <= {DATA_W{1'b0}};
                    if (slave_req) begin
                        cmd_r     <= slave_cmd;
                        idx_r     <= slave_addr[IDX_W-1:0];
                        wdata_r   <= slave_wdata;
                        lat_cnt_r <= LAT_LOAD;
                        if (LAT_ONE) begin
                            state_r <= ST_ACK;
                            ack_r   <= 1'b1;
                            rdata_r <= rd_val_s;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // slave_req is ignored here; the captured request is served
                    lat_cnt_r <= lat_cnt_r - 4'd1;
                    if (lat_cnt_r == 4'd1) begin
                        state_r <= ST_ACK;
                        ack_r   <= 1'b1;
                        rdata_r <= rd_val_s;
                    end else begin
                        state_r <= ST_WAIT;
                        ack_r   <= 1'b0;
                        rdata_r <= {DATA_W{1'b0}};
                    end
                end
                ST_ACK: begin
                    // Transaction completes at the edge ending this cycle
                    state_r <= ST_IDLE;
                    ack_r   <= 1'b0;
                    rdata_r <= {DATA_W{1'b0}};
                    if (cmd_r == CMD_WRITE) begin
                        wr_count_r <= wr_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        rd_count_r <= rd_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ack_r   <= 1'b0;
                    rdata_r <= {DATA_W{1'b0}};
                end
            endcase
        end
    end

    assign slave_ack   = ack_r;
    assign slave_rdata = rdata_r;
    assign wr_count    = wr_count_r;
    assign rd_count    = rd_count_r;

endmodule : crossbar_slave_responder

// File: tb/tb_crossbar_slave_responder.sv
// Directed bench for crossbar_slave_responder: one instance with LATENCY=1 and
// one with LATENCY=3, driven on the falling edge and sampled on the falling edge.
module tb_crossbar_slave_responder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // LATENCY=1 instance
    logic        reset1, req1, cmd1, ack1;
    logic [30:0] addr1;
    logic [31:0] wdata1, rdata1;
    logic [15:0] wrc1, rdc1;

    // LATENCY=3 instance
    logic        reset3, req3, cmd3, ack3;
    logic [30:0] addr3;
    logic [31:0] wdata3, rdata3;
    logic [15:0] wrc3, rdc3;

    int n_cmp = 0;
    int n_err = 0;

    crossbar_slave_responder #(.LATENCY(1)) u_dut1 (
        .clock(clock), .reset(reset1), .slave_req(req1), .slave_cmd(cmd1),
        .slave_addr(addr1), .slave_wdata(wdata1), .slave_ack(ack1),
        .slave_rdata(rdata1), .wr_count(wrc1), .rd_count(rdc1)
    );

    crossbar_slave_responder #(.LATENCY(3)) u_dut3 (
        .clock(clock), .reset(reset3), .slave_req(req3), .slave_cmd(cmd3),
        .slave_addr(addr3), .slave_wdata(wdata3), .slave_ack(ack3),
        .slave_rdata(rdata3), .wr_count(wrc3), .rd_count(rdc3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic r, input logic c,
                         input logic [30:0] a, input logic [31:0] w);
        if (d == 1) begin
            req1 = r; cmd1 = c; addr1 = a; wdata1 = w;
        end else begin
            req3 = r; cmd3 = c; addr3 = a; wdata3 = w;
        end
    endtask

    task automatic drive_idle(input int d);
        drive(d, 1'b0, 1'($urandom_range(0, 1)), 31'($urandom()), $urandom());
    endtask

    function automatic logic [31:0] get_ack(input int d);
        return (d == 1) ? {31'd0, ack1} : {31'd0, ack3};
    endfunction

    function automatic logic [31:0] get_rdata(input int d);
        return (d == 1) ? rdata1 : rdata3;
    endfunction

    function automatic logic [31:0] get_wrc(input int d);
        return (d == 1) ? {16'd0, wrc1} : {16'd0, wrc3};
    endfunction

    function automatic logic [31:0] get_rdc(input int d);
        return (d == 1) ? {16'd0, rdc1} : {16'd0, rdc3};
    endfunction

    // One transaction on instance d (d is also its latency); ack expected exactly d cycles after capture
    task automatic xact(input int d, input logic c, input logic [30:0] a,
                        input logic [31:0] w, input logic [31:0] exp_rd, input string tag);
        drive(d, 1'b1, c, a, w);
        for (int k = 1; k <= d; k++) begin
            @(negedge clock);
            chk({tag, "_ack"}, get_ack(d), (k == d) ? 32'd1 : 32'd0);
            if (c == 1'b0) chk({tag, "_rdata"}, get_rdata(d), (k == d) ? exp_rd : 32'd0);
        end
        drive_idle(d);
        @(negedge clock);
        chk({tag, "_ack_after"}, get_ack(d), 32'd0);
        chk({tag, "_rdata_after"}, get_rdata(d), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset both instances
        reset1 = 1'b1; reset3 = 1'b1;
        drive_idle(1); drive_idle(3);
        repeat (3) @(negedge clock);
        chk("rst_ack1", get_ack(1), 32'd0);
        chk("rst_rdata1", get_rdata(1), 32'd0);
        chk("rst_wrc1", get_wrc(1), 32'd0);
        chk("rst_rdc1", get_rdc(1), 32'd0);
        chk("rst_ack3", get_ack(3), 32'd0);
        chk("rst_rdata3", get_rdata(3), 32'd0);
        chk("rst_wrc3", get_wrc(3), 32'd0);
        chk("rst_rdc3", get_rdc(3), 32'd0);
        reset1 = 1'b0; reset3 = 1'b0;

        // 1: LATENCY=1 write then read of 0xA
        xact(1, 1'b1, 31'hA, 32'hA, 32'h0, "t1_wr");
        chk("t1_wrc", get_wrc(1), 32'd1);
        chk("t1_rdc0", get_rdc(1), 32'd0);
        xact(1, 1'b0, 31'hA, 32'h0, 32'h0000000A, "t1_rd");
        chk("t1_rdc", get_rdc(1), 32'd1);

        // 3: aliasing, upper address bits ignored
        xact(1, 1'b1, 31'h10B, 32'h55, 32'h0, "t3_wr");
        xact(1, 1'b0, 31'h00B, 32'h0, 32'h55, "t3_rd");
        xact(1, 1'b0, 31'h7FFFFF0B, 32'h0, 32'h55, "t3_rd_hi");
        chk("t3_wrc", get_wrc(1), 32'd2);
        chk("t3_rdc", get_rdc(1), 32'd3);

        // 4: req held across ack -> second ack LATENCY+1 cycles later
        reset1 = 1'b1;
        @(negedge clock);
        reset1 = 1'b0;
        chk("t4_wrc_rst", get_wrc(1), 32'd0);
        chk("t4_rdc_rst", get_rdc(1), 32'd0);
        drive(1, 1'b1, 1'b1, 31'h20, 32'h1234);
        @(negedge clock);
        chk("t4_ack1", get_ack(1), 32'd1);
        @(negedge clock);
        chk("t4_gap", get_ack(1), 32'd0);
        chk("t4_wrc_mid", get_wrc(1), 32'd1);
        @(negedge clock);
        chk("t4_ack2", get_ack(1), 32'd1);
        drive_idle(1);
        @(negedge clock);
        chk("t4_ack_end", get_ack(1), 32'd0);
        chk("t4_wrc", get_wrc(1), 32'd2);
        xact(1, 1'b0, 31'h20, 32'h0, 32'h1234, "t4_rd");
        xact(1, 1'b0, 31'h10B, 32'h0, 32'h55, "t4_mem_kept");
        chk("t4_rdc", get_rdc(1), 32'd2);

        // 2: LATENCY=3, address change during WAIT has no effect
        xact(3, 1'b1, 31'h5, 32'hCAFE0005, 32'h0, "t2_wr5");
        xact(3, 1'b1, 31'h6, 32'hBEEF0006, 32'h0, "t2_wr6");
        drive(3, 1'b1, 1'b0, 31'h5, 32'h0);
        @(negedge clock);
        chk("t2_wait1_ack", get_ack(3), 32'd0);
        chk("t2_wait1_rdata", get_rdata(3), 32'd0);
        drive(3, 1'b1, 1'b0, 31'h6, 32'hFFFF);
        @(negedge clock);
        chk("t2_wait2_ack", get_ack(3), 32'd0);
        chk("t2_wait2_rdata", get_rdata(3), 32'd0);
        @(negedge clock);
        chk("t2_ack", get_ack(3), 32'd1);
        chk("t2_rdata", get_rdata(3), 32'hCAFE0005);
        drive_idle(3);
        @(negedge clock);
        chk("t2_ack_end", get_ack(3), 32'd0);
        chk("t2_wrc", get_wrc(3), 32'd2);
        chk("t2_rdc", get_rdc(3), 32'd1);

        // 5: reset during WAIT of a write to 0x3
        xact(3, 1'b1, 31'h3, 32'h33333333, 32'h0, "t5_wr_old");
        chk("t5_wrc_old", get_wrc(3), 32'd3);
        drive(3, 1'b1, 1'b1, 31'h3, 32'hDEAD);
        @(negedge clock);
        chk("t5_wait_ack", get_ack(3), 32'd0);
        reset3 = 1'b1;
        drive_idle(3);
        @(negedge clock);
        reset3 = 1'b0;
        chk("t5_wrc_rst", get_wrc(3), 32'd0);
        chk("t5_rdc_rst", get_rdc(3), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("t5_no_ack", get_ack(3), 32'd0);
        end
        chk("t5_wrc", get_wrc(3), 32'd0);
        xact(3, 1'b0, 31'h3, 32'h0, 32'h33333333, "t5_rd");
        chk("t5_rdc", get_rdc(3), 32'd1);

        // 5b: reset during the ACK cycle of a write cancels the write and the count
        drive(3, 1'b1, 1'b1, 31'h3, 32'hBAD);
        @(negedge clock);
        @(negedge clock);
        chk("t5b_wait_ack", get_ack(3), 32'd0);
        @(negedge clock);
        chk("t5b_ack", get_ack(3), 32'd1);
        reset3 = 1'b1;
        drive_idle(3);
        @(negedge clock);
        reset3 = 1'b0;
        chk("t5b_ack_rst", get_ack(3), 32'd0);
        chk("t5b_wrc", get_wrc(3), 32'd0);
        chk("t5b_rdc", get_rdc(3), 32'd0);
        xact(3, 1'b0, 31'h3, 32'h0, 32'h33333333, "t5b_rd");
        chk("t5b_rdc_after", get_rdc(3), 32'd1);
        chk("t5b_wrc_after", get_wrc(3), 32'd0);

        // 6: idle with req=0 and junk on the other inputs
        for (int i = 0; i < 10; i++) begin
            drive_idle(1);
            drive_idle(3);
            @(negedge clock);
            chk("t6_ack1", get_ack(1), 32'd0);
            chk("t6_rdata1", get_rdata(1), 32'd0);
            chk("t6_ack3", get_ack(3), 32'd0);
            chk("t6_rdata3", get_rdata(3), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_crossbar_slave_responder
